// File: rtl/des_sbox_engine_pkg.sv
// des_pkg: shared widths, FSM state type and the eight DES S-box tables.
package des_pkg;

  localparam int DES_SBOX_IN_W  = 48;
  localparam int DES_SBOX_OUT_W = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } sbox_state_e;

  // DES_SBOX[box][row][col], box 0 = S1 ... box 7 = S8.
  localparam logic [3:0] DES_SBOX [8][4][16] = '{
    '{ // S1
      '{4'd14, 4'd4,  4'd13, 4'd1,  4'd2,  4'd15, 4'd11, 4'd8,  4'd3,  4'd10, 4'd6,  4'd12, 4'd5,  4'd9,  4'd0,  4'd7},
      '{4'd0,  4'd15, 4'd7,  4'd4,  4'd14, 4'd2,  4'd13, 4'd1,  4'd10, 4'd6,  4'd12, 4'd11, 4'd9,  4'd5,  4'd3,  4'd8},
      '{4'd4,  4'd1,  4'd14, 4'd8,  4'd13, 4'd6,  4'd2,  4'd11, 4'd15, 4'd12, 4'd9,  4'd7,  4'd3,  4'd10, 4'd5,  4'd0},
      '{4'd15, 4'd12, 4'd8,  4'd2,  4'd4,  4'd9,  4'd1,  4'd7,  4'd5,  4'd11, 4'd3,  4'd14, 4'd10, 4'd0,  4'd6,  4'd13}
    },
    '{ // S2
      '{4'd15, 4'd1,  4'd8,  4'd14, 4'd6,  4'd11, 4'd3,  4'd4,  4'd9,  4'd7,  4'd2,  4'd13, 4'd12, 4'd0,  4'd5,  4'd10},
      '{4'd3,  4'd13, 4'd4,  4'd7,  4'd15, 4'd2,  4'd8,  4'd14, 4'd12, 4'd0,  4'd1,  4'd10, 4'd6,  4'd9,  4'd11, 4'd5},
      '{4'd0,  4'd14, 4'd7,  4'd11, 4'd10, 4'd4,  4'd13, 4'd1,  4'd5,  4'd8,  4'd12, 4'd6,  4'd9,  4'd3,  4'd2,  4'd15},
      '{4'd13, 4'd8,  4'd10, 4'd1,  4'd3,  4'd15, 4'd4,  4'd2,  4'd11, 4'd6,  4'd7,  4'd12, 4'd0,  4'd5,  4'd14, 4'd9}
    },
    '{ // S3
      '{4'd10, 4'd0,  4'd9,  4'd14, 4'd6,  4'd3,  4'd15, 4'd5,  4'd1,  4'd13, 4'd12, 4'd7,  4'd11, 4'd4,  4'd2,  4'd8},
      '{4'd13, 4'd7,  4'd0,  4'd9,  4'd3,  4'd4,  4'd6,  4'd10, 4'd2,  4'd8,  4'd5,  4'd14, 4'd12, 4'd11, 4'd15, 4'd1},
      '{4'd13, 4'd6,  4'd4,  4'd9,  4'd8,  4'd15, 4'd3,  4'd0,  4'd11, 4'd1,  4'd2,  4'd12, 4'd5,  4'd10, 4'd14, 4'd7},
      '{4'd1,  4'd10, 4'd13, 4'd0,  4'd6,  4'd9,  4'd8,  4'd7,  4'd4,  4'd15, 4'd14, 4'd3,  4'd11, 4'd5,  4'd2,  4'd12}
    },
    '{ // S4
      '{4'd7,  4'd13, 4'd14, 4'd3,  4'd0,  4'd6,  4'd9,  4'd10, 4'd1,  4'd2,  4'd8,  4'd5,  4'd11, 4'd12, 4'd4,  4'd15},
      '{4'd13, 4'd8,  4'd11, 4'd5,  4'd6,  4'd15, 4'd0,  4'd3,  4'd4,  4'd7,  4'd2,  4'd12, 4'd1,  4'd10, 4'd14, 4'd9},
      '{4'd10, 4'd6,  4'd9,  4'd0,  4'd12, 4'd11, 4'd7,  4'd13, 4'd15, 4'd1,  4'd3,  4'd14, 4'd5,  4'd2,  4'd8,  4'd4},
      '{4'd3,  4'd15, 4'd0,  4'd6,  4'd10, 4'd1,  4'd13, 4'd8,  4'd9,  4'd4,  4'd5,  4'd11, 4'd12, 4'd7,  4'd2,  4'd14}
    },
    '{ // S5
      '{4'd2,  4'd12, 4'd4,  4'd1,  4'd7,  4'd10, 4'd11, 4'd6,  4'd8,  4'd5,  4'd3,  4'd15, 4'd13, 4'd0,  4'd14, 4'd9},
      '{4'd14, 4'd11, 4'd2,  4'd12, 4'd4,  4'd7,  4'd13, 4'd1,  4'd5,  4'd0,  4'd15, 4'd10, 4'd3,  4'd9,  4'd8,  4'd6},
      '{4'd4,  4'd2,  4'd1,  4'd11, 4'd10, 4'd13, 4'd7,  4'd8,  4'd15, 4'd9,  4'd12, 4'd5,  4'd6,  4'd3,  4'd0,  4'd14},
      '{4'd11, 4'd8,  4'd12, 4'd7,  4'd1,  4'd14, 4'd2,  4'd13, 4'd6,  4'd15, 4'd0,  4'd9,  4'd10, 4'd4,  4'd5,  4'd3}
    },
    '{ // S6
      '{4'd12, 4'd1,  4'd10, 4'd15, 4'd9,  4'd2,  4'd6,  4'd8,  4'd0,  4'd13, 4'd3,  4'd4,  4'd14, 4'd7,  4'd5,  4'd11},
      '{4'd10, 4'd15, 4'd4,  4'd2,  4'd7,  4'd12, 4'd9,  4'd5,  4'd6,  4'd1,  4'd13, 4'd14, 4'd0,  4'd11, 4'd3,  4'd8},
      '{4'd9,  4'd14, 4'd15, 4'd5,  4'd2,  4'd8,  4'd12, 4'd3,  4'd7,  4'd0,  4'd4,  4'd10, 4'd1,  4'd13, 4'd11, 4'd6},
      '{4'd4,  4'd3,  4'd2,  4'd12, 4'd9,  4'd5,  4'd15, 4'd10, 4'd11, 4'd14, 4'd1,  4'd7,  4'd6,  4'd0,  4'd8,  4'd13}
    },
    '{ // S7
      '{4'd4,  4'd11, 4'd2,  4'd14, 4'd15, 4'd0,  4'd8,  4'd13, 4'd3,  4'd12, 4'd9,  4'd7,  4'd5,  4'd10, 4'd6,  4'd1},
      '{4'd13, 4'd0,  4'd11, 4'd7,  4'd4,  4'd9,  4'd1,  4'd10, 4'd14, 4'd3,  4'd5,  4'd12, 4'd2,  4'd15, 4'd8,  4'd6},
      '{4'd1,  4'd4,  4'd11, 4'd13, 4'd12, 4'd3,  4'd7,  4'd14, 4'd10, 4'd15, 4'd6,  4'd8,  4'd0,  4'd5,  4'd9,  4'd2},
      '{4'd6,  4'd11, 4'd13, 4'd8,  4'd1,  4'd4,  4'd10, 4'd7,  4'd9,  4'd5,  4'd0,  4'd15, 4'd14, 4'd2,  4'd3,  4'd12}
    },
    '{ // S8
      '{4'd13, 4'd2,  4'd8,  4'd4,  4'd6,  4'd15, 4'd11, 4'd1,  4'd10, 4'd9,  4'd3,  4'd14, 4'd5,  4'd0,  4'd12, 4'd7},
      '{4'd1,  4'd15, 4'd13, 4'd8,  4'd10, 4'd3,  4'd7,  4'd4,  4'd12, 4'd5,  4'd6,  4'd11, 4'd0,  4'd14, 4'd9,  4'd2},
      '{4'd7,  4'd11, 4'd4,  4'd1,  4'd9,  4'd12, 4'd14, 4'd2,  4'd0,  4'd6,  4'd10, 4'd13, 4'd15, 4'd3,  4'd5,  4'd8},
      '{4'd2,  4'd1,  4'd14, 4'd7,  4'd4,  4'd10, 4'd8,  4'd13, 4'd15, 4'd12, 4'd9,  4'd0,  4'd3,  4'd5,  4'd6,  4'd11}
    }
  };

endpackage

// File: rtl/des_sbox_engine_if.sv
// des_sbox_engine_if: input and output valid/ready channels of the S-box engine.
interface des_sbox_engine_if;
  import des_pkg::*;

  logic                      in_valid;
  logic                      in_ready;
  logic [DES_SBOX_IN_W-1:0]  in_data;
  logic                      out_valid;
  logic                      out_ready;
  logic [DES_SBOX_OUT_W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data
  );

endinterface

// File: rtl/des_sbox_engine_lookup.sv
// des_sbox_lookup: single combinational S-box lookup, box selected at run time.
module des_sbox_lookup
  import des_pkg::*;
(
  input  logic [2:0] i_box,
  input  logic [5:0] i_chunk,
  output logic [3:0] o_value
);

  logic [1:0] w_row;
  logic [3:0] w_col;

  assign w_row   = {i_chunk[5], i_chunk[0]};
  assign w_col   = i_chunk[4:1];
  assign o_value = DES_SBOX[i_box][w_row][w_col];

endmodule

// File: rtl/des_sbox_engine.sv
// des_sbox_engine: applies S1..S8 to a 48-bit word, LANES boxes per cycle, valid/ready on both sides.
module des_sbox_engine
  import des_pkg::*;
#(
  parameter int LANES   = 8,
  parameter bit OUT_REG = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  des_sbox_engine_if.slave bus,
  output logic             busy
);

  localparam int NBATCH = 8 / LANES;
  localparam int CNT_W  = (NBATCH > 1) ? $clog2(NBATCH) : 1;
  localparam logic [CNT_W-1:0] LAST_BATCH = CNT_W'(NBATCH - 1);

  if (LANES != 1 && LANES != 2 && LANES != 4 && LANES != 8) begin : g_bad_lanes
    $fatal(1, "des_sbox_engine: LANES must be 1, 2, 4 or 8");
  end

  sbox_state_e              r_state;
  sbox_state_e              w_stateNext;
  logic [CNT_W-1:0]         r_batch;
  logic [DES_SBOX_IN_W-1:0] r_data;
  logic [0:7][3:0]          r_acc;
  logic [0:7][3:0]          w_accNext;
  logic [5:0]               w_chunks [8];
  logic [2:0]               w_box [LANES];
  logic [3:0]               w_val [LANES];
  logic                     w_accept;
  logic                     w_lastBatch;
  logic                     w_inReady;
  logic                     w_outValid;
  logic                     w_busy;

  assign w_accept    = (r_state == IDLE) && bus.in_valid;
  assign w_lastBatch = (r_batch == LAST_BATCH);

  for (genvar k = 0; k < 8; k++) begin : g_chunk
    assign w_chunks[k] = r_data[DES_SBOX_IN_W-1-6*k -: 6];
  end

  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [5:0] w_laneChunk;

    assign w_box[l]    = 3'(int'(r_batch) * LANES + l);
    assign w_laneChunk = w_chunks[w_box[l]];

    des_sbox_lookup u_lookup (
      .i_box   (w_box[l]),
      .i_chunk (w_laneChunk),
      .o_value (w_val[l])
    );
  end

  // State register; reset discards any partial computation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_stateNext;
    end
  end

  // Next-state decode and handshake outputs; unknown encodings fall back to IDLE.
  always_comb begin
    w_stateNext = r_state;
    w_inReady   = 1'b0;
    w_outValid  = 1'b0;
    w_busy      = 1'b0;
    case (r_state)
      IDLE: begin
        w_inReady = 1'b1;
        if (bus.in_valid) begin
          w_stateNext = BUSY;
        end
      end
      BUSY: begin
        w_busy = 1'b1;
        if (w_lastBatch) begin
          w_stateNext = DONE;
        end
      end
      DONE: begin
        w_outValid = 1'b1;
        if (bus.out_ready) begin
          w_stateNext = IDLE;
        end
      end
      default: begin
        w_stateNext = IDLE;
      end
    endcase
  end

  // Batch counter restarts on every accepted word and stops at the last batch.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_batch <= '0;
    end else if (w_accept) begin
      r_batch <= '0;
    end else if (r_state == BUSY && !w_lastBatch) begin
      r_batch <= r_batch + 1'b1;
    end
  end

  // Private copy of the input word so upstream may change in_data while we work.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data <= '0;
    end else if (w_accept) begin
      r_data <= bus.in_data;
    end
  end

  // Merge this cycle's lane results into the accumulator image.
  always_comb begin
    w_accNext = r_acc;
    for (int l = 0; l < LANES; l++) begin
      w_accNext[w_box[l]] = w_val[l];
    end
  end

  // Accumulator collects one batch of nibbles per BUSY cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc <= '0;
    end else if (r_state == BUSY) begin
      r_acc <= w_accNext;
    end
  end

  if (OUT_REG) begin : g_out_reg
    logic [DES_SBOX_OUT_W-1:0] r_out;

    // Capture the finished word on the same edge the last batch lands in the accumulator.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_out <= '0;
      end else if (r_state == BUSY && w_lastBatch) begin
        r_out <= w_accNext;
      end
    end

    assign bus.out_data = r_out;
  end else begin : g_out_acc
    assign bus.out_data = r_acc;
  end

  assign bus.in_ready  = w_inReady;
  assign bus.out_valid = w_outValid;
  assign busy          = w_busy;

endmodule
